// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue: a single-outstanding fetch engine that feeds a small FIFO sitting in front of IF/ID.
// Optional feature macro IF_PREFETCH_STATS_EN adds saturating redirect/discard counters.
module if_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    input  logic        stall,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic        ir_valid,
    output logic [15:0] ir_out,
    output logic [15:0] pc_out
`ifdef IF_PREFETCH_STATS_EN
    ,
    output logic [7:0]  redirect_cnt,
    output logic [7:0]  discard_cnt
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} state_t;

    state_t          state_q, state_d;
    logic [15:0]     fetch_pc_q, fetch_pc_d;
    logic [15:0]     stale_pc_q, stale_pc_d;
    logic [CW-1:0]   count_q, count_d, cnt_after_pop;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [15:0]     addr_mem [DEPTH];
    logic [15:0]     data_mem [DEPTH];
    logic            push, pop;

    assign ir_valid  = (count_q != '0);
    assign ir_out    = ir_valid ? data_mem[rd_ptr_q] : 16'h0000;
    assign pc_out    = ir_valid ? (addr_mem[rd_ptr_q] + 16'd2) : 16'h0000;
    assign imem_req  = (state_q != S_IDLE);
    // While discarding, the bus must keep showing the abandoned request's address.
    assign imem_addr = (state_q == S_DISCARD) ? stale_pc_q : fetch_pc_q;

    assign pop           = ir_valid && !stall && !redirect_valid;
    assign cnt_after_pop = count_q - CW'(pop);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        stale_pc_d = stale_pc_q;
        push       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (redirect_valid || (cnt_after_pop < DEPTH_C))
                    state_d = S_WAIT;
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    state_d    = imem_ack ? S_WAIT : S_DISCARD;
                    stale_pc_d = fetch_pc_q;
                end else if (imem_ack) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + 16'd2;
                    state_d    = ((cnt_after_pop + CW'(1)) < DEPTH_C) ? S_WAIT : S_IDLE;
                end
            end
            S_DISCARD: begin
                if (imem_ack)
                    state_d = S_WAIT;
            end
            default: state_d = S_IDLE;
        endcase
        if (redirect_valid)
            fetch_pc_d = redirect_pc & 16'hFFFE;
    end

    always_comb begin
        count_d  = count_q + CW'(push) - CW'(pop);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        wr_ptr_d = wr_ptr_q + AW'(push);
        if (redirect_valid) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            stale_pc_q <= RESET_PC;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            stale_pc_q <= stale_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= fetch_pc_q;
            data_mem[wr_ptr_q] <= imem_rdata;
        end
    end

`ifdef IF_PREFETCH_STATS_EN
    logic       drop;
    logic [7:0] redirect_cnt_q, discard_cnt_q;

    assign drop = imem_ack && ((state_q == S_DISCARD) || ((state_q == S_WAIT) && redirect_valid));

    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_cnt_q <= 8'h00;
            discard_cnt_q  <= 8'h00;
        end else begin
            if (redirect_valid && (redirect_cnt_q != 8'hFF))
                redirect_cnt_q <= redirect_cnt_q + 8'd1;
            if (drop && (discard_cnt_q != 8'hFF))
                discard_cnt_q <= discard_cnt_q + 8'd1;
        end
    end

    assign redirect_cnt = redirect_cnt_q;
    assign discard_cnt  = discard_cnt_q;
`endif

endmodule
